// File: rtl/code_pkg.sv
// Shared Hamming(11,7) serial-link definitions, used by both the encoder and
// the receiver (code_merge) sides.
//   BIT_CYCLES_DEF / SAMPLE_POINT_DEF : default serial timing
//   CODE_W / DATA_W                   : codeword and payload widths
//   state_e                           : receiver state machine encoding
//   PARITY_POS / DATA_POS             : Hamming positions (1-based)
//   SYN_MASK                          : per-syndrome-bit masks over codeword bits
package code_pkg;

  localparam int unsigned BIT_CYCLES_DEF   = 16;
  localparam int unsigned SAMPLE_POINT_DEF = 7;

  localparam int unsigned CODE_W = 11;
  localparam int unsigned DATA_W = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DECODE = 2'd2
  } state_e;

  localparam int unsigned PARITY_POS [4]      = '{1, 2, 4, 8};
  localparam int unsigned DATA_POS   [DATA_W] = '{3, 5, 6, 7, 9, 10, 11};

  // Codeword bit i is Hamming position i+1; mask b selects the bits whose
  // position has bit b set, so XOR-reducing under it gives syndrome bit b.
  localparam logic [CODE_W-1:0] SYN_MASK [4] = '{11'h555, 11'h666, 11'h078, 11'h780};

endpackage

// File: rtl/hamming11_dec.sv
// Combinational Hamming(11,7) decoder.
//   code_in  : raw 11-bit codeword (bit i = position i+1)
//   data_out : 7 data bits (positions 3,5,6,7,9,10,11), corrected when possible
//   errfix   : syndrome in 1..11, the addressed bit was flipped back
//   errbad   : syndrome in 12..15, data passed through uncorrected
module hamming11_dec
  import code_pkg::*;
(
  input  logic [CODE_W-1:0] code_in,
  output logic [DATA_W-1:0] data_out,
  output logic              errfix,
  output logic              errbad
);

  logic [3:0]        syn;
  logic [CODE_W-1:0] fixed;

  for (genvar b = 0; b < 4; b++) begin : g_syn
    assign syn[b] = ^(code_in & SYN_MASK[b]);
  end

  always_comb begin
    fixed  = code_in;
    errfix = 1'b0;
    errbad = 1'b0;
    if (syn != 4'd0) begin
      if (syn <= 4'(CODE_W)) begin
        fixed  = code_in ^ (11'd1 << (syn - 4'd1));
        errfix = 1'b1;
      end else begin
        errbad = 1'b1;
      end
    end
  end

  for (genvar j = 0; j < DATA_W; j++) begin : g_data
    assign data_out[j] = fixed[DATA_POS[j]-1];
  end

endmodule

// File: rtl/code_merge.sv
// Serial Hamming(11,7) receiver: samples an LSB-first codeword framed by
// 'sending', then decodes it and publishes the result with a done pulse.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   codein     : serial line, BIT_CYCLES clocks per bit
//   sending    : frame valid, a rising edge starts a frame (in IDLE only)
//   codeout    : last complete raw codeword
//   dataout    : corrected data of that word; errfix / errbad its status
//   done       : one-cycle pulse when the outputs above update
//   frame_err  : one-cycle pulse when sending drops before the last bit
//   busy       : receiver in SHIFT or DECODE
module code_merge
  import code_pkg::*;
#(
  parameter int unsigned BIT_CYCLES   = BIT_CYCLES_DEF,
  parameter int unsigned SAMPLE_POINT = SAMPLE_POINT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              codein,
  input  logic              sending,
  output logic [CODE_W-1:0] codeout,
  output logic [DATA_W-1:0] dataout,
  output logic              done,
  output logic              errfix,
  output logic              errbad,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [CODE_W-1:0] shift_q, shift_d;
  logic              sending_q, sending_d;
  logic [CODE_W-1:0] codeout_q, codeout_d;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic              errfix_q, errfix_d;
  logic              errbad_q, errbad_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;

  logic [DATA_W-1:0] dec_data;
  logic              dec_fix, dec_bad;
  logic              sample;

  hamming11_dec u_dec (
    .code_in  (shift_q),
    .data_out (dec_data),
    .errfix   (dec_fix),
    .errbad   (dec_bad)
  );

  assign sample = (cnt_q == CNT_W'(SAMPLE_POINT));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    sending_d = sending;
    codeout_d = codeout_q;
    dataout_d = dataout_q;
    errfix_d  = errfix_q;
    errbad_d  = errbad_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sending && !sending_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        if (sample) shift_d[idx_q] = codein;
        // Last-bit sample takes priority so a drop of sending on that very
        // edge still completes the frame.
        if (sample && idx_q == 4'(CODE_W - 1)) begin
          state_d = DECODE;
        end else if (!sending) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end else if (cnt_q == CNT_W'(BIT_CYCLES - 1)) begin
          cnt_d = '0;
          idx_d = idx_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DECODE: begin
        state_d   = IDLE;
        done_d    = 1'b1;
        codeout_d = shift_q;
        dataout_d = dec_data;
        errfix_d  = dec_fix;
        errbad_d  = dec_bad;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      sending_q <= 1'b0;
      codeout_q <= '0;
      dataout_q <= '0;
      errfix_q  <= 1'b0;
      errbad_q  <= 1'b0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      sending_q <= sending_d;
      codeout_q <= codeout_d;
      dataout_q <= dataout_d;
      errfix_q  <= errfix_d;
      errbad_q  <= errbad_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  assign codeout   = codeout_q;
  assign dataout   = dataout_q;
  assign errfix    = errfix_q;
  assign errbad    = errbad_q;
  assign done      = done_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_code_merge.sv
// Bench for code_merge: serial frames are driven at 16 clocks/bit and the
// outputs are compared with a positional Hamming(11,7) model.
module tb_code_merge;

  localparam int BC = 16;
  localparam int SP = 7;
  localparam int DONE_C = 169;  // edge index (start edge = 0) whose result shows done

  logic        clk = 1'b0;
  logic        reset, codein, sending;
  logic [10:0] codeout;
  logic [6:0]  dataout;
  logic        done, errfix, errbad, frame_err, busy;

  int errors = 0;
  int checks = 0;

  // bench-side view of what the held outputs must currently be
  logic [10:0] exp_code;
  logic [6:0]  exp_data;
  logic        exp_fix, exp_bad;

  // per-frame observations
  int   r_done_cnt, r_done_at, r_ferr_cnt, r_ferr_at;
  logic r_busy0, r_busy_end;

  always #5 clk = ~clk;

  code_merge #(.BIT_CYCLES(BC), .SAMPLE_POINT(SP)) dut (
    .clk(clk), .reset(reset), .codein(codein), .sending(sending),
    .codeout(codeout), .dataout(dataout), .done(done), .errfix(errfix),
    .errbad(errbad), .frame_err(frame_err), .busy(busy)
  );

  // Hamming encode: data bits at positions 3,5,6,7,9,10,11; parity at the
  // powers of two chosen so the XOR of all set positions is zero.
  function automatic logic [10:0] encode(input logic [6:0] d);
    int dpos [7] = '{3, 5, 6, 7, 9, 10, 11};
    logic [10:0] w = '0;
    int s = 0;
    for (int j = 0; j < 7; j++)
      if (d[j]) begin w[dpos[j]-1] = 1'b1; s = s ^ dpos[j]; end
    for (int b = 0; b < 4; b++)
      if (s[b]) w[(1 << b) - 1] = 1'b1;
    return w;
  endfunction

  task automatic ref_decode(input logic [10:0] w, output logic [6:0] d,
                            output logic fx, output logic bd);
    int s = 0;
    logic [10:0] c = w;
    for (int i = 0; i < 11; i++) if (w[i]) s = s ^ (i + 1);
    fx = (s >= 1 && s <= 11);
    bd = (s >= 12);
    if (fx) c[s-1] = ~c[s-1];
    d = {c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
  endtask

  // Called at a falling edge. Drives nbits bits (BC edges each) with sending
  // high, then 'gap' edges with sending low and random codein. Edge c=0 is
  // the start edge; results of edge c are observed at the following negedge.
  task automatic run_frame(input logic [10:0] w, input int nbits, input int gap);
    int total = nbits * BC + gap;
    r_done_cnt = 0; r_done_at = -1; r_ferr_cnt = 0; r_ferr_at = -1;
    for (int c = 0; c < total; c++) begin
      if (c < nbits * BC) begin sending = 1'b1; codein = w[c / BC]; end
      else begin sending = 1'b0; codein = 1'($urandom_range(0, 1)); end
      @(negedge clk);
      if (done) begin r_done_cnt++; r_done_at = c; end
      if (frame_err) begin r_ferr_cnt++; r_ferr_at = c; end
      if (c == 0) r_busy0 = busy;
    end
    r_busy_end = busy;
  endtask

  task automatic expect_word(input logic [10:0] w);
    exp_code = w;
    ref_decode(w, exp_data, exp_fix, exp_bad);
  endtask

  task automatic test_reset;
    reset = 1'b1; sending = 1'b0; codein = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (codeout !== 11'h0) begin errors++; $display("FAIL reset_codeout: got %h want 000", codeout); end
    checks++; if (dataout !== 7'h0) begin errors++; $display("FAIL reset_dataout: got %h want 00", dataout); end
    checks++; if ({done, errfix, errbad, frame_err, busy} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {done, errfix, errbad, frame_err, busy}); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    exp_code = '0; exp_data = '0; exp_fix = 1'b0; exp_bad = 1'b0;
  endtask

  task automatic check_frame(input string nm);
    checks++; if (r_done_cnt !== 1 || r_done_at !== DONE_C) begin errors++; $display("FAIL %s_done: got %0d pulses at %0d want 1 at %0d", nm, r_done_cnt, r_done_at, DONE_C); end
    checks++; if (r_ferr_cnt !== 0) begin errors++; $display("FAIL %s_ferr: got %0d pulses want 0", nm, r_ferr_cnt); end
    checks++; if (codeout !== exp_code) begin errors++; $display("FAIL %s_codeout: got %h want %h", nm, codeout, exp_code); end
    checks++; if (dataout !== exp_data) begin errors++; $display("FAIL %s_dataout: got %h want %h", nm, dataout, exp_data); end
    checks++; if ({errfix, errbad} !== {exp_fix, exp_bad}) begin errors++; $display("FAIL %s_errflags: got %b want %b", nm, {errfix, errbad}, {exp_fix, exp_bad}); end
  endtask

  task automatic test_clean;
    logic [10:0] w = encode(7'h5A);
    run_frame(w, 11, 2);
    expect_word(w);
    check_frame("clean");
    checks++; if (exp_data !== 7'h5A || exp_fix !== 1'b0) begin errors++; $display("FAIL clean_model: got %h want 5a", exp_data); end
    checks++; if (r_busy0 !== 1'b1 || r_busy_end !== 1'b0) begin errors++; $display("FAIL clean_busy: got %b%b want 10", r_busy0, r_busy_end); end
  endtask

  task automatic test_single_err;
    logic [10:0] w = encode(7'h5A) ^ 11'b000_0010_0000;  // position 6
    run_frame(w, 11, 2);
    expect_word(w);
    check_frame("single");
    checks++; if (dataout !== 7'h5A || errfix !== 1'b1) begin errors++; $display("FAIL single_fixed: got %h/%b want 5a/1", dataout, errfix); end
  endtask

  task automatic test_uncorrectable;
    logic [10:0] w = encode(7'h5A) ^ 11'b000_1000_1001;  // positions 1,4,8 -> S=13
    run_frame(w, 11, 2);
    expect_word(w);
    check_frame("bad");
    checks++; if (errbad !== 1'b1 || errfix !== 1'b0 || dataout !== 7'h5A) begin errors++; $display("FAIL bad_flags: got %b%b/%h want 10/5a", errbad, errfix, dataout); end
  endtask

  task automatic test_frame_abort;
    logic [10:0] w = encode(7'($urandom));
    run_frame(encode(7'($urandom)), 5, 20);
    checks++; if (r_ferr_cnt !== 1 || r_ferr_at !== 5 * BC) begin errors++; $display("FAIL abort_ferr: got %0d pulses at %0d want 1 at %0d", r_ferr_cnt, r_ferr_at, 5 * BC); end
    checks++; if (r_done_cnt !== 0) begin errors++; $display("FAIL abort_nodone: got %0d pulses want 0", r_done_cnt); end
    checks++; if (codeout !== exp_code || dataout !== exp_data || {errfix, errbad} !== {exp_fix, exp_bad}) begin errors++; $display("FAIL abort_hold: got %h/%h want %h/%h", codeout, dataout, exp_code, exp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    run_frame(w, 11, 2);
    expect_word(w);
    check_frame("after_abort");
  endtask

  task automatic test_reset_midframe;
    logic [10:0] w = encode(7'h5A);
    logic [10:0] w2 = encode(7'h33);
    for (int c = 0; c < 4 * BC + 4; c++) begin
      sending = 1'b1; codein = w[c / BC];
      @(negedge clk);
    end
    reset = 1'b1; sending = 1'b0;
    @(negedge clk);
    checks++; if (codeout !== 11'h0 || dataout !== 7'h0) begin errors++; $display("FAIL midrst_data: got %h/%h want 000/00", codeout, dataout); end
    checks++; if ({done, errfix, errbad, frame_err, busy} !== 5'b0) begin errors++; $display("FAIL midrst_flags: got %b want 00000", {done, errfix, errbad, frame_err, busy}); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(w2, 11, 2);
    expect_word(w2);
    check_frame("midrst");
  endtask

  task automatic test_start_after_reset;
    logic [10:0] w = encode(7'h6C);
    reset = 1'b1; sending = 1'b1; codein = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_frame(w, 11, 2);
    expect_word(w);
    check_frame("rst_start");
  endtask

  task automatic test_back_to_back;
    logic [10:0] w1 = encode(7'($urandom));
    logic [10:0] w2 = encode(7'($urandom)) ^ 11'(1 << $urandom_range(0, 10));
    run_frame(w1, 11, 2);
    expect_word(w1);
    check_frame("b2b_first");
    run_frame(w2, 11, 2);
    expect_word(w2);
    check_frame("b2b_second");
  endtask

  task automatic test_random;
    for (int n = 0; n < 8; n++) begin
      logic [10:0] w = encode(7'($urandom));
      int flips = $urandom_range(0, 2);
      for (int f = 0; f < flips; f++) w[$urandom_range(0, 10)] ^= 1'b1;
      run_frame(w, 11, 2 + $urandom_range(0, 5));
      expect_word(w);
      check_frame("random");
    end
  endtask

  initial begin
    reset = 1'b1; sending = 1'b0; codein = 1'b0;
    @(negedge clk);
    test_reset;
    test_clean;
    test_single_err;
    test_uncorrectable;
    test_frame_abort;
    test_reset_midframe;
    test_start_after_reset;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
